uart_ram_cmd_ctrl: RTL

- Byte-command controller between the UART byte receiver/transmitter and the frame buffer RAM (15-bit address, 8-bit data).
- Decodes single-byte commands from UART RX: ping, address reset/increment, address and RAM readback, and bulk load of a fixed-length block into RAM.
- Produces one-cycle transmit strobes with data toward UART TX.

---
 rtl/uart_ram_pkg.sv | 20 ++
 rtl/uart_ram_cmd_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_ram_pkg.sv
// rtl/uart_ram_pkg.sv - command bytes and FSM states shared by the UART/RAM command controller
package uart_ram_pkg;

    localparam logic [7:0] CMD_PING     = 8'h55;
    localparam logic [7:0] RSP_PING     = 8'h44;
    localparam logic [7:0] CMD_ADDR_CLR = 8'hBB;
    localparam logic [7:0] CMD_ADDR_INC = 8'hDD;
    localparam logic [7:0] CMD_ADDR_RD  = 8'hAA;
    localparam logic [7:0] CMD_RAM_RD   = 8'hCC;
    localparam logic [7:0] CMD_LOAD     = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_WR,
        READ,
        TX
    } state_e;

endpackage

// File: rtl/uart_ram_cmd_ctrl.sv
// rtl/uart_ram_cmd_ctrl.sv - byte-command controller between UART and frame RAM
// Define UART_RAM_LOAD_CHECKSUM_EN to reply with the modulo-256 sum of each loaded block.
module uart_ram_cmd_ctrl
    import uart_ram_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int LOAD_LEN = 102,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wren,
    input  logic [7:0]        ram_rdata,
    output logic              load_active
);

    state_e              state_q;
    logic                tx_start_q;
    logic [7:0]          tx_data_q;
    logic [7:0]          tx_hold_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic                wren_q;
    logic                load_active_q;
    logic [ADDR_W:0]     remain_q;
    logic [1:0]          rd_cnt_q;
`ifdef UART_RAM_LOAD_CHECKSUM_EN
    logic [7:0]          sum_q;
`endif

    logic                send_d;
    logic [7:0]          send_byte_d;
    logic [ADDR_W-1:0]   addr_inc_d;

    assign addr_inc_d = addr_q + ADDR_W'(1);

    // Every state that produces a reply byte funnels through send_d so the
    // busy/back-to-back handling lives in one place.
    always_comb begin
        send_d      = 1'b0;
        send_byte_d = tx_hold_q;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == CMD_PING) begin
                    send_d      = 1'b1;
                    send_byte_d = RSP_PING;
                end else if (rx_valid && rx_data == CMD_ADDR_RD) begin
                    send_d      = 1'b1;
                    send_byte_d = addr_q[7:0];
                end
            end
            READ: begin
                if (rd_cnt_q == 2'(RD_LAT - 1)) begin
                    send_d      = 1'b1;
                    send_byte_d = ram_rdata;
                end
            end
`ifdef UART_RAM_LOAD_CHECKSUM_EN
            LOAD_WR: begin
                if (remain_q == '0) begin
                    send_d      = 1'b1;
                    send_byte_d = sum_q;
                end
            end
`endif
            TX:      send_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_hold_q     <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wren_q        <= 1'b0;
            load_active_q <= 1'b0;
            remain_q      <= '0;
            rd_cnt_q      <= '0;
`ifdef UART_RAM_LOAD_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            wren_q     <= 1'b0;
            if (send_d) begin
                // A pulse in the previous cycle forces a detour through TX.
                if (!tx_busy && !tx_start_q) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= send_byte_d;
                    state_q    <= IDLE;
                end else begin
                    tx_hold_q <= send_byte_d;
                    state_q   <= TX;
                end
                if (state_q == LOAD_WR) begin
                    load_active_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_valid) begin
                            case (rx_data)
                                CMD_ADDR_CLR: addr_q <= '0;
                                CMD_ADDR_INC: addr_q <= addr_inc_d;
                                CMD_RAM_RD: begin
                                    rd_cnt_q <= '0;
                                    state_q  <= READ;
                                end
                                CMD_LOAD: begin
                                    remain_q      <= (ADDR_W+1)'(LOAD_LEN);
                                    load_active_q <= 1'b1;
                                    state_q       <= LOAD;
`ifdef UART_RAM_LOAD_CHECKSUM_EN
                                    sum_q         <= '0;
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                    LOAD: begin
                        if (rx_valid) begin
                            wdata_q  <= rx_data;
                            wren_q   <= 1'b1;
                            remain_q <= remain_q - (ADDR_W+1)'(1);
                            state_q  <= LOAD_WR;
`ifdef UART_RAM_LOAD_CHECKSUM_EN
                            sum_q    <= sum_q + rx_data;
`endif
                        end
                    end
                    LOAD_WR: begin
                        if (remain_q != '0) begin
                            addr_q  <= addr_inc_d;
                            state_q <= LOAD;
                        end else begin
                            load_active_q <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                    READ:    rd_cnt_q <= rd_cnt_q + 2'd1;
                    default: ;
                endcase
            end
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_wren    = wren_q;
    assign load_active = load_active_q;

endmodule
